// File: rtl/univ_shift_reg_if.sv
// rtl/univ_shift_reg_if.sv - control, data and status bundle for univ_shift_reg
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             En;
    logic [1:0]       Mode;
    logic [WIDTH-1:0] D;
    logic             SerInR;
    logic             SerInL;
    logic [WIDTH-1:0] Q;
    logic             SerOutR;
    logic             SerOutL;
    logic [CNT_W-1:0] Count;
    logic             Done;

    modport master (
        output En, Mode, D, SerInR, SerInL,
        input  Q, SerOutR, SerOutL, Count, Done
    );

    modport slave (
        input  En, Mode, D, SerInR, SerInL,
        output Q, SerOutR, SerOutL, Count, Done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with saturating shift counter and done pulse
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic             CLK,
    input logic             Reset,
    univ_shift_reg_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_r, q_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic             done_r, done_nxt;
    logic             shifting;

    assign shifting = bus.En && ((bus.Mode == MODE_SHR) || (bus.Mode == MODE_SHL));

    always_comb begin
        q_nxt    = q_r;
        cnt_nxt  = cnt_r;
        done_nxt = 1'b0;

        if (bus.En) begin
            case (bus.Mode)
                MODE_HOLD: q_nxt = q_r;
                MODE_SHR:  q_nxt = {bus.SerInR, q_r[WIDTH-1:1]};
                MODE_SHL:  q_nxt = {q_r[WIDTH-2:0], bus.SerInL};
                MODE_LOAD: begin
                    q_nxt   = bus.D;
                    cnt_nxt = '0;
                end
                default:   q_nxt = q_r;
            endcase
        end

        // Saturation at WIDTH both stops the count and keeps Done from re-firing.
        if (shifting) begin
            if (cnt_r != CNT_MAX) begin
                cnt_nxt = cnt_r + CNT_W'(1);
            end
            done_nxt = (cnt_r == CNT_LAST);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            q_r    <= RESET_VAL;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            cnt_r  <= cnt_nxt;
            done_r <= done_nxt;
        end
    end

    assign bus.Q       = q_r;
    assign bus.SerOutR = q_r[0];
    assign bus.SerOutL = q_r[WIDTH-1];
    assign bus.Count   = cnt_r;
    assign bus.Done    = done_r;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed self-checking bench for univ_shift_reg
module tb_univ_shift_reg;
    logic CLK;
    logic Reset;
    int   tests;
    int   errors;

    univ_shift_reg_if #(.WIDTH(8)) bus ();

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One rising edge; returns on the following falling edge where outputs are checked and inputs changed.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic load(input logic [7:0] val);
        bus.En = 1'b1; bus.Mode = 2'b11; bus.D = val;
        step();
        bus.Mode = 2'b00;
    endtask

    task automatic test_reset();
        Reset = 1'b1; bus.En = 1'b1; bus.Mode = 2'b11; bus.D = 8'hFF;
        bus.SerInR = 1'b0; bus.SerInL = 1'b0;
        step(); step();
        tests++; if (bus.Q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", bus.Q); end
        tests++; if (bus.Count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.Count); end
        tests++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.Done); end
        Reset = 1'b0;
        load(8'hFF);
        tests++; if (bus.Q !== 8'hFF) begin errors++; $display("FAIL reset_then_load got %h want ff", bus.Q); end
    endtask

    task automatic test_piso();
        logic [7:0] exp_bits;
        exp_bits = 8'hA5;
        load(8'hA5);
        tests++; if (bus.SerOutL !== 1'b1 || bus.SerOutR !== 1'b1) begin errors++; $display("FAIL piso_load_serout got L%b R%b want L1 R1", bus.SerOutL, bus.SerOutR); end
        bus.SerInR = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests++; if (bus.SerOutR !== exp_bits[i]) begin errors++; $display("FAIL piso_serout_bit%0d got %b want %b", i, bus.SerOutR, exp_bits[i]); end
            tests++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL piso_early_done at %0d got %b want 0", i, bus.Done); end
            bus.Mode = 2'b01;
            step();
        end
        tests++; if (bus.Q !== 8'h00) begin errors++; $display("FAIL piso_q got %h want 00", bus.Q); end
        tests++; if (bus.Done !== 1'b1) begin errors++; $display("FAIL piso_done got %b want 1", bus.Done); end
        tests++; if (bus.Count !== 4'd8) begin errors++; $display("FAIL piso_count got %0d want 8", bus.Count); end
        step();
        tests++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL piso_sat_done got %b want 0", bus.Done); end
        tests++; if (bus.Count !== 4'd8) begin errors++; $display("FAIL piso_sat_count got %0d want 8", bus.Count); end
        bus.Mode = 2'b00;
    endtask

    task automatic test_sipo();
        logic [7:0] ser;
        int pulses;
        ser = 8'b1101_0011;
        pulses = 0;
        load(8'h00);
        for (int i = 0; i < 8; i++) begin
            bus.Mode = 2'b10; bus.SerInL = ser[i];
            step();
            if (bus.Done === 1'b1) pulses++;
        end
        bus.Mode = 2'b00;
        step();
        if (bus.Done === 1'b1) pulses++;
        tests++; if (bus.Q !== 8'hCB) begin errors++; $display("FAIL sipo_q got %h want cb", bus.Q); end
        tests++; if (pulses != 1) begin errors++; $display("FAIL sipo_done_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_enable_hold();
        int pulses;
        pulses = 0;
        load(8'h3C);
        bus.SerInR = 1'b0; bus.Mode = 2'b01;
        step(); step(); step();
        bus.En = 1'b0;
        for (int i = 0; i < 4; i++) step();
        tests++; if (bus.Q !== 8'h07) begin errors++; $display("FAIL en_hold_q got %h want 07", bus.Q); end
        tests++; if (bus.Count !== 4'd3) begin errors++; $display("FAIL en_hold_count got %0d want 3", bus.Count); end
        bus.En = 1'b1; bus.Mode = 2'b00;
        step(); step();
        tests++; if (bus.Q !== 8'h07 || bus.Count !== 4'd3) begin errors++; $display("FAIL mode_hold got q=%h cnt=%0d want q=07 cnt=3", bus.Q, bus.Count); end
        bus.Mode = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.Done === 1'b1) pulses++;
            if (i == 4) begin
                tests++; if (bus.Done !== 1'b1) begin errors++; $display("FAIL en_resume_done got %b want 1", bus.Done); end
            end
        end
        tests++; if (pulses != 1) begin errors++; $display("FAIL en_resume_pulses got %0d want 1", pulses); end
        bus.Mode = 2'b00;
    endtask

    task automatic test_load_mid();
        int first_done;
        first_done = -1;
        load(8'hFF);
        bus.Mode = 2'b01; bus.SerInR = 1'b0;
        for (int i = 0; i < 5; i++) step();
        load(8'h81);
        tests++; if (bus.Count !== 4'd0 || bus.Done !== 1'b0) begin errors++; $display("FAIL load_mid got cnt=%0d done=%b want cnt=0 done=0", bus.Count, bus.Done); end
        tests++; if (bus.Q !== 8'h81) begin errors++; $display("FAIL load_mid_q got %h want 81", bus.Q); end
        bus.Mode = 2'b10; bus.SerInL = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (bus.Done === 1'b1 && first_done < 0) first_done = i;
        end
        tests++; if (first_done != 8) begin errors++; $display("FAIL load_mid_done_at got %0d want 8", first_done); end
        bus.Mode = 2'b00;
    endtask

    task automatic test_reset_mid();
        load(8'h5A);
        bus.Mode = 2'b01; bus.SerInR = 1'b1;
        for (int i = 0; i < 7; i++) step();
        tests++; if (bus.Count !== 4'd7) begin errors++; $display("FAIL rst_mid_precount got %0d want 7", bus.Count); end
        Reset = 1'b1;
        step();
        tests++; if (bus.Q !== 8'h00 || bus.Count !== 4'd0 || bus.Done !== 1'b0) begin errors++; $display("FAIL rst_mid got q=%h cnt=%0d done=%b want q=00 cnt=0 done=0", bus.Q, bus.Count, bus.Done); end
        Reset = 1'b0; bus.Mode = 2'b00;
        step();
        tests++; if (bus.Done !== 1'b0 || bus.Q !== 8'h00) begin errors++; $display("FAIL rst_mid_after got q=%h done=%b want q=00 done=0", bus.Q, bus.Done); end
    endtask

    initial begin
        tests = 0; errors = 0;
        Reset = 1'b1;
        bus.En = 1'b0; bus.Mode = 2'b00; bus.D = 8'h00;
        bus.SerInR = 1'b0; bus.SerInL = 1'b0;
        @(negedge CLK);
        test_reset();
        test_piso();
        test_sipo();
        test_enable_hold();
        test_load_mid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: the multi-bit successor to the single-bit D flip-flop. Each rising edge of `CLK` it can hold, shift right, shift left or parallel-load a `WIDTH`-bit word, gated by a clock enable. A shift counter with a one-cycle `Done` pulse lets it act directly as a serialiser (PISO) or deserialiser (SIPO) in datapath and serial-link blocks.

## Interface
- `WIDTH`, default 8: register width in bits; must be ≥ 2.
- `RESET_VAL`, default 0: value loaded into `Q` on reset; `WIDTH` bits.
- `CNT_W`, derived as `$clog2(WIDTH+1)`: width of `Count`; not overridden.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset; sampled on the rising edge of `CLK`.
- `En`  in  1  clock enable; 0 means every register holds.
- `Mode`  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `D`  in  `WIDTH`  parallel load data.
- `SerInR`  in  1  bit entering the MSB on a shift right.
- `SerInL`  in  1  bit entering the LSB on a shift left.
- `Q`  out  `WIDTH`  register contents.
- `SerOutR`  out  1  equals `Q[0]` (combinational from `Q`).
- `SerOutL`  out  1  equals `Q[WIDTH-1]` (combinational from `Q`).
- `Count`  out  `CNT_W`  shifts since the last load or reset; saturates at `WIDTH`.
- `Done`  out  1  registered pulse when `Count` reaches `WIDTH`.

## Operation
- **Priority:** `Reset` > `En` = 0 > `Mode`.
- **Reset:**
  - `Q` = `RESET_VAL`, `Count` = 0, `Done` = 0.
  - `Reset` takes effect regardless of `En`.
  - `Reset` asserted mid-serialisation abandons the word; no `Done` is produced.
- **`En` = 0:** `Q` and `Count` hold; `Done` = 0.
- **`En` = 1, by `Mode`:**
  - Hold (00): `Q` and `Count` unchanged; `Done` = 0.
  - Shift right (01): `Q` ← {`SerInR`, `Q[WIDTH-1:1]`}; `Count` increments.
  - Shift left (10): `Q` ← {`Q[WIDTH-2:0]`, `SerInL`}; `Count` increments.
  - Parallel load (11): `Q` ← `D`; `Count` ← 0; `Done` = 0.
- **Count arithmetic:**
  - Unsigned, saturating at `WIDTH`; it never wraps.
  - At `Count` = `WIDTH`, further shifts still move data, but `Count` stays at `WIDTH`.
  - Direction does not matter: mixed left and right shifts all increment `Count`.
- **`Done`:**
  - Asserted for exactly one cycle, in the cycle after the edge where `Count` goes from `WIDTH-1` to `WIDTH`.
  - Not re-asserted while saturated.
  - Re-arms only after a parallel load or `Reset`.
- **Bit shifted out:** `SerOutR`/`SerOutL` present the bit that the next right/left shift discards. The consumer samples it before that edge.

## Timing
- All outputs are registered or derived combinationally from registers. There are no combinational paths from inputs to outputs.
- **Load → serial output:** 1 cycle. After a load edge, `SerOutR` = `D[0]` immediately.
- **`Done` latency:** `Done` is high in the same cycle that `Count` first reads `WIDTH`. For 8 consecutive enabled shifts after a load, that is the cycle following the 8th shift edge.
- **Reset:** deasserting `Reset` allows normal operation at the next rising edge.
- **Inputs:** `Mode`, `D`, `SerInR`, `SerInL` and `En` are sampled only at the rising edge. Benches drive them on the falling edge.

## Test plan
All scenarios use `WIDTH` = 8 and `RESET_VAL` = 8'h00.

1. **Reset:**
   - Drive `Reset` = 1 for 2 edges with `Mode` = 11, `D` = 8'hFF, `En` = 1 → `Q` = 8'h00, `Count` = 0, `Done` = 0.
   - Release `Reset`, then load → `Q` = 8'hFF.
2. **PISO:**
   - Load 8'hA5, then 8 shift-right edges with `SerInR` = 0.
   - → `SerOutR` sequence before each edge is 1,0,1,0,0,1,0,1.
   - → `Q` = 8'h00 and `Done` = 1 for exactly one cycle after the 8th edge.
   - A 9th shift → `Count` stays 8, `Done` = 0.
3. **SIPO:**
   - After a load of 8'h00, shift left 8 edges with `SerInL` = 1,1,0,0,1,0,1,1.
   - → `Q` = 8'hCB, `Done` pulses once.
4. **Enable and hold:**
   - Load 8'h3C, shift right 3 times, drop `En` for 4 edges with `Mode` = 01.
   - → `Q` stays at 8'h07 (`SerInR` = 0), `Count` = 3.
   - Re-enable, 5 more shifts → `Done` pulses.
   - `Mode` = 00 with `En` = 1 also holds.
5. **Load mid-shift:**
   - After 5 shifts, load 8'h81 → `Count` = 0, no `Done`.
   - 8 further shifts are needed for `Done`.
6. **Reset mid-operation:**
   - After 7 shifts, assert `Reset` together with `Mode` = 01.
   - → `Q` = 8'h00, `Count` = 0, and no `Done` in the following cycle.
